// File: rtl/dtw_pkg.sv
// Shared definitions for the DTW run controller: FSM state encoding,
// control/status register bit positions and the default query length.
package dtw_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_LOAD  = 3'd2,
    S_SWEEP = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam int CR_START   = 0;
  localparam int CR_ABORT   = 1;

  localparam int SR_BUSY    = 0;
  localparam int SR_DONE    = 1;
  localparam int SR_ERR_LEN = 2;
  localparam int SR_ERR_TMO = 3;
  localparam int SR_ST_LO   = 4;

  localparam int QUERY_LEN_DEF = 250;

endpackage

// File: rtl/dtw_sweep_cnt.sv
// Counters for one DTW run: reference address, query sample index and
// drain timeout.
// Ports: i_clk/i_rst clock and async reset; i_clr latches i_len and
//   zeroes the query index; i_load zeroes the address; i_step advances
//   the address; i_next_q advances the query index; i_tmo_en runs the
//   drain timer. o_ref_addr, o_last_addr, o_last_q, o_tmo report position.
module dtw_sweep_cnt
  import dtw_pkg::*;
#(
  parameter int QUERY_LEN = QUERY_LEN_DEF,
  parameter int REF_AW    = 16,
  parameter int DRAIN_TMO = 255
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clr,
  input  logic [REF_AW-1:0] i_len,
  input  logic              i_load,
  input  logic              i_step,
  input  logic              i_next_q,
  input  logic              i_tmo_en,
  output logic [REF_AW-1:0] o_ref_addr,
  output logic              o_last_addr,
  output logic              o_last_q,
  output logic              o_tmo
);

  localparam int QW = (QUERY_LEN > 1) ? $clog2(QUERY_LEN) : 1;
  localparam int TW = $clog2(DRAIN_TMO + 1);
  localparam logic [QW-1:0] Q_LAST = QW'(QUERY_LEN - 1);
  localparam logic [TW-1:0] T_LAST = TW'(DRAIN_TMO - 1);

  logic [REF_AW-1:0] r_len;
  logic [REF_AW-1:0] r_addr;
  logic [QW-1:0]     r_q_cnt;
  logic [TW-1:0]     r_tmo_cnt;

  assign o_ref_addr  = r_addr;
  assign o_last_addr = (r_addr == r_len - REF_AW'(1));
  assign o_last_q    = (r_q_cnt == Q_LAST);
  assign o_tmo       = i_tmo_en && (r_tmo_cnt == T_LAST);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_len     <= '0;
      r_addr    <= '0;
      r_q_cnt   <= '0;
      r_tmo_cnt <= '0;
    end else begin
      if (i_clr) begin
        r_len   <= i_len;
        r_q_cnt <= '0;
      end else if (i_next_q) begin
        r_q_cnt <= r_q_cnt + QW'(1);
      end
      // The address parks on len-1 at the end of a sweep, so the
      // largest length never wraps it.
      if (i_load) begin
        r_addr <= '0;
      end else if (i_step && !o_last_addr) begin
        r_addr <= r_addr + REF_AW'(1);
      end
      // Timer only runs while draining and restarts on every entry.
      if (i_tmo_en) begin
        r_tmo_cnt <= r_tmo_cnt + TW'(1);
      end else begin
        r_tmo_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/dtw_ctrl.sv
// DTW run controller: sequences matrix clear, per-sample load and
// reference sweeps, then waits for the core's final score.
// Ports: S_AXI_ACLK/S_AXI_ARESET clock and async reset; dtw_cr control
//   (start/abort); dtw_ref_len reference length; dtw_sr status;
//   s_query_* query stream; core_* DTW core strobes and data;
//   ref_addr reference address; result_score captured score.
module dtw_ctrl
  import dtw_pkg::*;
#(
  parameter int QUERY_LEN = QUERY_LEN_DEF,
  parameter int REF_AW    = 16,
  parameter int DRAIN_TMO = 255
) (
  input  logic              S_AXI_ACLK,
  input  logic              S_AXI_ARESET,
  input  logic [31:0]       dtw_cr,
  input  logic [31:0]       dtw_ref_len,
  output logic [31:0]       dtw_sr,
  input  logic              s_query_tvalid,
  output logic              s_query_tready,
  input  logic [15:0]       s_query_tdata,
  output logic              core_clear,
  output logic              core_en,
  output logic [15:0]       core_query,
  output logic [REF_AW-1:0] ref_addr,
  input  logic              core_score_valid,
  input  logic [31:0]       core_score,
  output logic [31:0]       result_score
);

  state_t      r_state;
  state_t      w_nxt;
  logic        r_start_q;
  logic        r_done;
  logic        r_err_len;
  logic        r_err_tmo;
  logic [15:0] r_query;
  logic [31:0] r_score;

  logic w_start;
  logic w_abort;
  logic w_len_nz;
  logic w_go;
  logic w_len_err;
  logic w_clr;
  logic w_load;
  logic w_step;
  logic w_next_q;
  logic w_tmo_en;
  logic w_cap;
  logic w_set_tmo;
  logic w_last_addr;
  logic w_last_q;
  logic w_tmo;
  logic w_unused;

  assign w_start  = dtw_cr[CR_START] & ~r_start_q;
  assign w_abort  = dtw_cr[CR_ABORT];
  assign w_len_nz = |dtw_ref_len[REF_AW-1:0];
  assign w_unused = ^{dtw_cr[31:2], dtw_ref_len[31:REF_AW]};

  assign core_query   = r_query;
  assign result_score = r_score;

  dtw_sweep_cnt #(
    .QUERY_LEN (QUERY_LEN),
    .REF_AW    (REF_AW),
    .DRAIN_TMO (DRAIN_TMO)
  ) u_cnt (
    .i_clk       (S_AXI_ACLK),
    .i_rst       (S_AXI_ARESET),
    .i_clr       (w_clr),
    .i_len       (dtw_ref_len[REF_AW-1:0]),
    .i_load      (w_load),
    .i_step      (w_step),
    .i_next_q    (w_next_q),
    .i_tmo_en    (w_tmo_en),
    .o_ref_addr  (ref_addr),
    .o_last_addr (w_last_addr),
    .o_last_q    (w_last_q),
    .o_tmo       (w_tmo)
  );

  always_comb begin
    w_nxt          = r_state;
    core_clear     = 1'b0;
    core_en        = 1'b0;
    s_query_tready = 1'b0;
    w_go           = 1'b0;
    w_len_err      = 1'b0;
    w_clr          = 1'b0;
    w_load         = 1'b0;
    w_step         = 1'b0;
    w_next_q       = 1'b0;
    w_tmo_en       = 1'b0;
    w_cap          = 1'b0;
    w_set_tmo      = 1'b0;
    // Abort masks every strobe in the same cycle so nothing is
    // consumed or captured on the way back to idle.
    if (w_abort) begin
      w_nxt = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_start) begin
            if (w_len_nz) begin
              w_go  = 1'b1;
              w_nxt = S_CLEAR;
            end else begin
              w_len_err = 1'b1;
            end
          end
        end
        S_CLEAR: begin
          core_clear = 1'b1;
          w_clr      = 1'b1;
          w_nxt      = S_LOAD;
        end
        S_LOAD: begin
          s_query_tready = 1'b1;
          if (s_query_tvalid) begin
            w_load = 1'b1;
            w_nxt  = S_SWEEP;
          end
        end
        S_SWEEP: begin
          core_en = 1'b1;
          w_step  = 1'b1;
          if (w_last_addr) begin
            if (w_last_q) begin
              w_nxt = S_DRAIN;
            end else begin
              w_next_q = 1'b1;
              w_nxt    = S_LOAD;
            end
          end
        end
        S_DRAIN: begin
          w_tmo_en = 1'b1;
          if (core_score_valid) begin
            w_cap = 1'b1;
            w_nxt = S_DONE;
          end else if (w_tmo) begin
            w_set_tmo = 1'b1;
            w_nxt     = S_DONE;
          end
        end
        S_DONE: begin
          w_nxt = S_IDLE;
        end
        default: begin
          w_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      r_state   <= S_IDLE;
      r_start_q <= 1'b0;
      r_done    <= 1'b0;
      r_err_len <= 1'b0;
      r_err_tmo <= 1'b0;
      r_query   <= '0;
      r_score   <= '0;
    end else begin
      r_state   <= w_nxt;
      r_start_q <= dtw_cr[CR_START];
      if (w_go) begin
        r_done    <= 1'b0;
        r_err_len <= 1'b0;
        r_err_tmo <= 1'b0;
      end
      if (w_len_err) r_err_len <= 1'b1;
      if (w_set_tmo) r_err_tmo <= 1'b1;
      if (w_cap | w_set_tmo) r_done <= 1'b1;
      if (w_load) r_query <= s_query_tdata;
      if (w_cap) r_score <= core_score;
    end
  end

  always_comb begin
    dtw_sr                  = '0;
    dtw_sr[SR_BUSY]         = (r_state != S_IDLE);
    dtw_sr[SR_DONE]         = r_done;
    dtw_sr[SR_ERR_LEN]      = r_err_len;
    dtw_sr[SR_ERR_TMO]      = r_err_tmo;
    dtw_sr[SR_ST_LO +: 3]   = r_state;
  end

endmodule

// File: tb/tb_dtw_ctrl.sv
// Directed bench for dtw_ctrl with QUERY_LEN=4, REF_AW=4, DRAIN_TMO=8.
// Each task drives one scenario and compares against hand-derived values.
module tb_dtw_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] cr = '0;
  logic [31:0] ref_len = '0;
  logic [31:0] sr;
  logic        tvalid = 1'b0;
  logic        tready;
  logic [15:0] tdata = '0;
  logic        core_clear;
  logic        core_en;
  logic [15:0] core_query;
  logic [3:0]  ref_addr;
  logic        score_valid = 1'b0;
  logic [31:0] core_score = '0;
  logic [31:0] result_score;

  int total = 0;
  int bad = 0;

  dtw_ctrl #(
    .QUERY_LEN (4),
    .REF_AW    (4),
    .DRAIN_TMO (8)
  ) dut (
    .S_AXI_ACLK       (clk),
    .S_AXI_ARESET     (rst),
    .dtw_cr           (cr),
    .dtw_ref_len      (ref_len),
    .dtw_sr           (sr),
    .s_query_tvalid   (tvalid),
    .s_query_tready   (tready),
    .s_query_tdata    (tdata),
    .core_clear       (core_clear),
    .core_en          (core_en),
    .core_query       (core_query),
    .ref_addr         (ref_addr),
    .core_score_valid (score_valid),
    .core_score       (core_score),
    .result_score     (result_score)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one job from a start pulse back to IDLE and reports what it saw.
  task automatic run_job(
    input  int len, input int score_dly, input int stall_ld,
    output int en_cnt, output int nruns, output int badrun,
    output int addr_bad, output int qbad, output int hs_bad,
    output int clr_cnt, output int dcnt, output bit to);
    int run_len = 0;
    int nload = 0;
    int stall_left = 5;
    bit in_run = 0;
    bit seen_done = 0;
    logic [15:0] exp_q = '0;
    en_cnt = 0; nruns = 0; badrun = 0; addr_bad = 0;
    qbad = 0; hs_bad = 0; clr_cnt = 0; dcnt = 0; to = 1;
    score_valid = 0;
    tvalid = 1;
    ref_len = len;
    cr = 32'h1;
    tick();
    cr = 32'h0;
    if (core_clear === 1'b1) clr_cnt++;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (core_clear === 1'b1) clr_cnt++;
      if (core_en === 1'b1) begin
        if (!in_run) begin
          nruns++;
          run_len = 0;
          if (core_query !== exp_q) qbad++;
        end
        if (ref_addr !== 4'(run_len)) addr_bad++;
        run_len++;
        en_cnt++;
        in_run = 1;
      end else if (in_run) begin
        if (run_len != len) badrun++;
        in_run = 0;
      end
      if (sr[6:4] == 3'd2) begin
        if (tready !== 1'b1) hs_bad++;
        if (nload == stall_ld && stall_left > 0) begin
          tvalid = 0;
          stall_left--;
        end else begin
          tvalid = 1;
          tdata = 16'hA000 + 16'(nload);
          exp_q = tdata;
          nload++;
        end
      end else if (tready !== 1'b0) begin
        hs_bad++;
      end
      if (sr[6:4] == 3'd4) begin
        dcnt++;
        if (score_dly >= 0 && dcnt == score_dly) begin
          score_valid = 1;
          core_score = 32'h1234;
        end
      end
      if (sr[6:4] == 3'd5) begin
        score_valid = 0;
        seen_done = 1;
      end
      if (sr[6:4] == 3'd0 && seen_done) begin
        to = 0;
        break;
      end
    end
    score_valid = 0;
  endtask

  task automatic test_reset();
    #12;
    rst = 0;
    #1;
    total++;
    if (sr !== 32'h0) begin
      bad++; $display("FAIL reset_sr got=%0h want=0", sr);
    end
    total++;
    if ({core_clear, core_en, tready} !== 3'b000) begin
      bad++; $display("FAIL reset_strobes got=%b want=000",
                      {core_clear, core_en, tready});
    end
    total++;
    if ({core_query, ref_addr, result_score} !== 52'h0) begin
      bad++; $display("FAIL reset_data got=%0h/%0h/%0h want=0",
                      core_query, ref_addr, result_score);
    end
    tick();
  endtask

  task automatic test_latency();
    ref_len = 3;
    tvalid = 0;
    cr = 32'h3;
    tick();
    total++;
    if (sr[6:4] !== 3'd0) begin
      bad++; $display("FAIL abort_over_start got=%0d want=0", sr[6:4]);
    end
    cr = 0;
    tick();
    cr = 32'h1;
    tick();
    total++;
    if (sr[6:4] !== 3'd1 || sr[0] !== 1'b1 || core_clear !== 1'b1) begin
      bad++; $display("FAIL lat_clear got=st%0d busy%b clr%b want=st1 1 1",
                      sr[6:4], sr[0], core_clear);
    end
    cr = 0;
    tick();
    total++;
    if (sr[6:4] !== 3'd2 || tready !== 1'b1 || core_clear !== 1'b0) begin
      bad++; $display("FAIL lat_load got=st%0d rdy%b clr%b want=st2 1 0",
                      sr[6:4], tready, core_clear);
    end
    cr = 32'h1;
    tick();
    total++;
    if (sr[6:4] !== 3'd2) begin
      bad++; $display("FAIL start_busy got=%0d want=2", sr[6:4]);
    end
    cr = 32'h3;
    tick();
    cr = 32'h1;
    tick();
    tick();
    tick();
    total++;
    if (sr !== 32'h0) begin
      bad++; $display("FAIL level_hold got=%0h want=0", sr);
    end
    cr = 0;
    tick();
  endtask

  task automatic test_main();
    int e, n, br, ab, qb, hb, cc, dc;
    bit to;
    run_job(3, 2, -1, e, n, br, ab, qb, hb, cc, dc, to);
    total++;
    if (to || e != 12 || n != 4 || br != 0) begin
      bad++; $display("FAIL main_sweep got=to%0d en%0d runs%0d br%0d want=0 12 4 0",
                      to, e, n, br);
    end
    total++;
    if (ab != 0 || qb != 0 || hb != 0 || cc != 1) begin
      bad++; $display("FAIL main_addr got=ab%0d qb%0d hb%0d clr%0d want=0 0 0 1",
                      ab, qb, hb, cc);
    end
    total++;
    if (result_score !== 32'h1234 || sr !== 32'h2) begin
      bad++; $display("FAIL main_result got=%0h sr=%0h want=1234 sr=2",
                      result_score, sr);
    end
  endtask

  task automatic test_len_zero();
    int busy_seen = 0;
    int clr_seen = 0;
    ref_len = 0;
    cr = 32'h1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (sr[0] === 1'b1) busy_seen++;
      if (core_clear === 1'b1) clr_seen++;
    end
    cr = 0;
    tick();
    total++;
    if (busy_seen != 0 || clr_seen != 0) begin
      bad++; $display("FAIL len0_idle got=busy%0d clr%0d want=0 0",
                      busy_seen, clr_seen);
    end
    total++;
    if (sr !== 32'h6) begin
      bad++; $display("FAIL len0_sr got=%0h want=6", sr);
    end
  endtask

  task automatic test_stall();
    int e, n, br, ab, qb, hb, cc, dc;
    bit to;
    run_job(3, 2, 2, e, n, br, ab, qb, hb, cc, dc, to);
    total++;
    if (to || e != 12 || n != 4 || br != 0 || ab != 0) begin
      bad++; $display("FAIL stall_sweep got=to%0d en%0d runs%0d br%0d ab%0d want=0 12 4 0 0",
                      to, e, n, br, ab);
    end
    total++;
    if (hb != 0 || qb != 0) begin
      bad++; $display("FAIL stall_hs got=hb%0d qb%0d want=0 0", hb, qb);
    end
    total++;
    if (sr !== 32'h2) begin
      bad++; $display("FAIL stall_sr got=%0h want=2", sr);
    end
  endtask

  task automatic test_abort();
    int e, n, br, ab, qb, hb, cc, dc;
    bit to;
    bit hit = 0;
    ref_len = 3;
    tvalid = 1;
    cr = 32'h1;
    tick();
    cr = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (core_en === 1'b1 && ref_addr === 4'd1) begin
        hit = 1;
        break;
      end
    end
    total++;
    if (!hit) begin
      bad++; $display("FAIL abort_reach got=0 want=1");
    end
    cr = 32'h2;
    tick();
    cr = 0;
    total++;
    if (sr !== 32'h0 || core_en !== 1'b0 || tready !== 1'b0) begin
      bad++; $display("FAIL abort_idle got=sr%0h en%b rdy%b want=0 0 0",
                      sr, core_en, tready);
    end
    total++;
    if (result_score !== 32'h1234) begin
      bad++; $display("FAIL abort_score got=%0h want=1234", result_score);
    end
    tick();
    run_job(3, 2, -1, e, n, br, ab, qb, hb, cc, dc, to);
    total++;
    if (to || e != 12 || n != 4 || br != 0 || ab != 0 || sr !== 32'h2) begin
      bad++; $display("FAIL abort_rerun got=to%0d en%0d runs%0d sr%0h want=0 12 4 2",
                      to, e, n, sr);
    end
  endtask

  task automatic test_timeout();
    int e, n, br, ab, qb, hb, cc, dc;
    bit to;
    run_job(2, -1, -1, e, n, br, ab, qb, hb, cc, dc, to);
    total++;
    if (to || dc != 8 || e != 8) begin
      bad++; $display("FAIL tmo_drain got=to%0d drain%0d en%0d want=0 8 8",
                      to, dc, e);
    end
    total++;
    if (sr !== 32'hA || result_score !== 32'h1234) begin
      bad++; $display("FAIL tmo_sr got=%0h score=%0h want=a 1234",
                      sr, result_score);
    end
  endtask

  task automatic test_max_len();
    int e, n, br, ab, qb, hb, cc, dc;
    bit to;
    run_job(15, 1, -1, e, n, br, ab, qb, hb, cc, dc, to);
    total++;
    if (to || e != 60 || n != 4 || br != 0 || ab != 0) begin
      bad++; $display("FAIL maxlen got=to%0d en%0d runs%0d br%0d ab%0d want=0 60 4 0 0",
                      to, e, n, br, ab);
    end
    total++;
    if (sr !== 32'h2) begin
      bad++; $display("FAIL maxlen_sr got=%0h want=2", sr);
    end
  endtask

  task automatic test_len_one();
    int e, n, br, ab, qb, hb, cc, dc;
    bit to;
    run_job(1, 1, -1, e, n, br, ab, qb, hb, cc, dc, to);
    total++;
    if (to || e != 4 || n != 4 || br != 0 || ab != 0) begin
      bad++; $display("FAIL len1 got=to%0d en%0d runs%0d br%0d want=0 4 4 0",
                      to, e, n, br);
    end
  endtask

  task automatic test_async_reset();
    bit hit = 0;
    ref_len = 3;
    tvalid = 1;
    cr = 32'h1;
    tick();
    cr = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (core_en === 1'b1 && ref_addr === 4'd1) begin
        hit = 1;
        break;
      end
    end
    #2;
    rst = 1;
    #1;
    total++;
    if (!hit || sr !== 32'h0 || {core_clear, core_en, tready} !== 3'b000) begin
      bad++; $display("FAIL arst_ctl got=hit%0d sr%0h str%b want=1 0 000",
                      hit, sr, {core_clear, core_en, tready});
    end
    total++;
    if ({core_query, ref_addr, result_score} !== 52'h0) begin
      bad++; $display("FAIL arst_data got=%0h/%0h/%0h want=0",
                      core_query, ref_addr, result_score);
    end
    #2;
    rst = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_main();
    test_len_zero();
    test_stall();
    test_abort();
    test_timeout();
    test_max_len();
    test_len_one();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
